ram_port_arbiter: RTL and testbench
===================================

Name: ram_port_arbiter

Overview:
Shares one RAM-style memory port between the three mm2s read requesters and the single s2mm write requester of top_sa_ram. Requesters keep the existing en/addr/data/wait/ack protocol. The block performs round-robin arbitration, tracks outstanding requests in an in-order ID FIFO, and routes each memory ack (and read data) back to the requester that issued it. It sits between the top_sa_ram DMA ports and a single memory or AXI bridge port.

Parameters:
N_RD, 3, number of read requesters (mm2s ports); requester index N_RD is the writer
AXI_WIDTH, 128, data width in bits
AXI_ADDR_WIDTH, 32, address width
AXI_STRB_WIDTH, AXI_WIDTH/8, write strobe width
MAX_OUT, 4, maximum outstanding accepted-but-unacked requests (power of 2, ≥2)

Ports:
clk  in  1  clock
rstn  in  1  synchronous active-low reset
rd_en  in  N_RD  per-reader request
rd_addr  in  N_RD*AXI_ADDR_WIDTH  per-reader address, held while rd_en && rd_wait
rd_wait  out  N_RD  request not accepted this cycle
rd_ack  out  N_RD  read completion pulse
rd_data  out  N_RD*AXI_WIDTH  read data, valid with rd_ack
wr_en  in  1  write request
wr_addr  in  AXI_ADDR_WIDTH  write address
wr_data  in  AXI_WIDTH  write data
wr_strb  in  AXI_STRB_WIDTH  byte strobes
wr_wait  out  1  write not accepted this cycle
wr_ack  out  1  write completion pulse
mem_en  out  1  memory request
mem_we  out  1  1 = write
mem_addr  out  AXI_ADDR_WIDTH  memory address
mem_wdata  out  AXI_WIDTH  memory write data
mem_wstrb  out  AXI_STRB_WIDTH  memory strobes, 0 on reads
mem_rdata  in  AXI_WIDTH  memory read data, valid with mem_ack
mem_wait  in  1  memory not accepting this cycle
mem_ack  in  1  in-order completion pulse
err  out  1  sticky protocol error

Behaviour:
- Acceptance: a request is accepted in a cycle where its en=1, it is granted, mem_wait=0 and the FIFO can push. Acceptance is combinational in the same cycle. Non-granted requesters with en=1 see wait=1. wait is don't-care when en=0 and is driven 1.
- Grant: round-robin over the N_RD+1 requesters, combinational from the en bits and rr_ptr. rr_ptr resets to 0. On acceptance, rr_ptr <= granted index + 1, modulo N_RD+1. The pointer does not move without an acceptance.
- mem_en = (any en) && can_push. The mem_* fields are muxed from the granted requester. mem_en does not depend on mem_wait (no combinational loop).
- ID FIFO: depth MAX_OUT, stores the granted index on acceptance. count range is 0..MAX_OUT.
- can_push = (count < MAX_OUT) || mem_ack. A simultaneous push and pop at full is allowed, and count is unchanged.
- Completion: on mem_ack with count > 0, pop the head. If head < N_RD, pulse rd_ack[head] and drive rd_data[head] = mem_rdata. Otherwise pulse wr_ack. Zero-cycle combinational routing.
- Unused rd_data lanes hold their last value (registered capture of mem_rdata on each routed ack). The ack pulse itself is combinational.
- mem_ack with count == 0 is a protocol error: ignored, and err <= 1 (sticky until reset).
- Reset (rstn=0 sampled at posedge):
  - rr_ptr=0, count=0, FIFO pointers 0, err=0, rd_data=0.
  - While rstn=0, mem_en=0, all waits=1 and all acks=0, forced combinationally.
  - Reset mid-operation drops all outstanding IDs. Later acks for them raise err.

Optional Feature:
Macro ARB_WR_PRIORITY_EN.
- Defined: the writer (index N_RD) has strict priority whenever wr_en=1. Readers round-robin among themselves only when wr_en=0, and rr_ptr ranges over 0..N_RD-1.
- Undefined: the writer is an equal round-robin participant as described in Behaviour.

Decomposition:
- Package ram_arb_pkg: localparam N_REQ = N_RD+1, ID_W = $clog2(N_REQ), CNT_W = $clog2(MAX_OUT)+1, and typedef logic [ID_W-1:0] req_id_t.
- Sub-module ram_arb_id_fifo: synchronous FIFO with simultaneous push/pop, full/empty and count outputs.

Test Plan:
1. Single read: rd_en[1]=1, addr 0x100, mem_wait=0, mem_ack 2 cycles later with data 0xA5..A5. Expect mem_en=1, we=0, addr 0x100 in cycle 0; rd_ack[1] pulses in cycle 2 with rd_data[1]=0xA5..A5; other acks stay 0.
2. All four requesters asserted continuously, immediate acks. Expect grants in order 0,1,2,3,0 over 5 cycles; each reader sees wait=1 for 3 of every 4 cycles. With ARB_WR_PRIORITY_EN, expect grants 3,3,3… while wr_en=1.
3. Full FIFO: MAX_OUT=4 with no acks for 4 accepts, then a 5th request. Expect wait=1 and mem_en=0. In a cycle where mem_ack=1 and a request are both present, expect acceptance and count to stay at 4.
4. Out-of-arbiter stall: mem_wait=1 for 3 cycles with rd_en[0]=1. Expect rd_wait[0]=1, rr_ptr unchanged, and a single acceptance when mem_wait drops.
5. Ack routing order: accepts from 2, then 3 (write, strb 0x00FF), then 0. Three acks return rd_ack[2], then wr_ack, then rd_ack[0], in that order.
6. Spurious ack and reset: assert mem_ack with count=0 and expect err=1 with no acks. Then with 2 outstanding, pulse rstn=0 for one cycle; expect count=0 and err=0, and the next ack sets err again.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared sizing, types and helpers for the RAM port arbiter.
// The optional feature is selected by the ARB_WR_PRIORITY_EN macro.
package ram_arb_pkg;

  localparam int N_RD           = 3;
  localparam int AXI_WIDTH      = 128;
  localparam int AXI_ADDR_WIDTH = 32;
  localparam int AXI_STRB_WIDTH = AXI_WIDTH / 8;
  localparam int MAX_OUT        = 4;

  localparam int N_REQ = N_RD + 1;
  localparam int ID_W  = $clog2(N_REQ);
  localparam int CNT_W = $clog2(MAX_OUT) + 1;
  localparam int PTR_W = $clog2(MAX_OUT);

  typedef logic [ID_W-1:0]  req_id_t;
  typedef logic [CNT_W-1:0] cnt_t;

  // The writer always occupies the last requester slot.
  localparam req_id_t WR_ID = req_id_t'(N_RD);

  function automatic req_id_t wrap_inc(req_id_t idx, int unsigned modulo);
    return (32'(idx) + 32'd1 >= modulo) ? '0 : idx + 1'b1;
  endfunction

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Requester and memory-side signals of the RAM port arbiter.
// slave = arbiter view, master = requesters plus memory.
interface ram_port_arbiter_if;
  import ram_arb_pkg::*;

  logic [N_RD-1:0]                     rd_en;
  logic [N_RD-1:0][AXI_ADDR_WIDTH-1:0] rd_addr;
  logic [N_RD-1:0]                     rd_wait;
  logic [N_RD-1:0]                     rd_ack;
  logic [N_RD-1:0][AXI_WIDTH-1:0]      rd_data;

  logic                      wr_en;
  logic [AXI_ADDR_WIDTH-1:0] wr_addr;
  logic [AXI_WIDTH-1:0]      wr_data;
  logic [AXI_STRB_WIDTH-1:0] wr_strb;
  logic                      wr_wait;
  logic                      wr_ack;

  logic                      mem_en;
  logic                      mem_we;
  logic [AXI_ADDR_WIDTH-1:0] mem_addr;
  logic [AXI_WIDTH-1:0]      mem_wdata;
  logic [AXI_STRB_WIDTH-1:0] mem_wstrb;
  logic [AXI_WIDTH-1:0]      mem_rdata;
  logic                      mem_wait;
  logic                      mem_ack;

  modport slave (
    input  rd_en, rd_addr, wr_en, wr_addr, wr_data, wr_strb,
           mem_rdata, mem_wait, mem_ack,
    output rd_wait, rd_ack, rd_data, wr_wait, wr_ack,
           mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb
  );

  modport master (
    output rd_en, rd_addr, wr_en, wr_addr, wr_data, wr_strb,
           mem_rdata, mem_wait, mem_ack,
    input  rd_wait, rd_ack, rd_data, wr_wait, wr_ack,
           mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb
  );

endinterface

// File: rtl/ram_arb_id_fifo.sv
// In-order FIFO of requester IDs for accepted-but-unacked memory requests.
// Push and pop may coincide, including when full; the caller never overflows it.
module ram_arb_id_fifo
  import ram_arb_pkg::*;
(
  input  logic    clk,
  input  logic    rstn,
  input  logic    push,
  input  logic    pop,
  input  req_id_t din,
  output req_id_t head,
  output logic    full,
  output logic    empty,
  output cnt_t    count
);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  cnt_t             cnt_q, cnt_d;
  req_id_t          mem_q [MAX_OUT];
  req_id_t          mem_d [MAX_OUT];

  // NOTE: every always_comb output gets its default first so no path leaves it unassigned (no latch).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    mem_d    = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // NOTE: state registers use non-blocking assignment so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // NOTE: the storage array is not reset; an entry is only read after it was written.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head  = mem_q[rd_ptr_q];
  assign full  = (cnt_q == CNT_W'(MAX_OUT));
  assign empty = (cnt_q == '0);
  assign count = cnt_q;

endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin share of one memory port between N_RD readers and one writer,
// with in-order ack routing. ARB_WR_PRIORITY_EN gives the writer strict priority.
module ram_port_arbiter
  import ram_arb_pkg::*;
(
  input  logic                clk,
  input  logic                rstn,
  ram_port_arbiter_if.slave   bus,
  output logic                err
);

  logic [N_REQ-1:0] req_en;
  req_id_t          rr_ptr_q, rr_ptr_d;
  req_id_t          grant, cand, head;
  logic             found;
  logic             any_en, can_push, accept, pop, full, empty;
  logic             err_q, err_d;
  cnt_t             count;
  logic [N_RD-1:0][AXI_WIDTH-1:0] rd_data_q, rd_data_d;

  assign req_en   = {bus.wr_en, bus.rd_en};
  assign any_en   = |req_en;
  assign can_push = !full || bus.mem_ack;
  assign accept   = rstn && any_en && can_push && !bus.mem_wait;
  assign pop      = rstn && bus.mem_ack && !empty;

  always_comb begin
    grant = rr_ptr_q;
    cand  = '0;
    found = 1'b0;
`ifdef ARB_WR_PRIORITY_EN
    if (bus.wr_en) begin
      grant = WR_ID;
      found = 1'b1;
    end
    for (int k = 0; k < N_RD; k++) begin
      cand = req_id_t'((32'(rr_ptr_q) + 32'(k)) % 32'(N_RD));
      if (!found && bus.rd_en[cand]) begin
        grant = cand;
        found = 1'b1;
      end
    end
`else
    for (int k = 0; k < N_REQ; k++) begin
      cand = req_id_t'((32'(rr_ptr_q) + 32'(k)) % 32'(N_REQ));
      if (!found && req_en[cand]) begin
        grant = cand;
        found = 1'b1;
      end
    end
`endif
  end

  // mem_en deliberately ignores mem_wait so the memory may derive wait from en.
  always_comb begin
    bus.mem_en    = rstn && any_en && can_push;
    bus.mem_we    = (grant == WR_ID);
    bus.mem_addr  = bus.wr_addr;
    bus.mem_wdata = bus.wr_data;
    bus.mem_wstrb = bus.wr_strb;
    if (grant != WR_ID) begin
      bus.mem_addr  = bus.rd_addr[grant];
      bus.mem_wdata = '0;
      bus.mem_wstrb = '0;
    end
    for (int i = 0; i < N_RD; i++) begin
      bus.rd_wait[i] = !(accept && grant == req_id_t'(i));
    end
    bus.wr_wait = !(accept && grant == WR_ID);
  end

  // Completion routing: the FIFO head names the requester that owns this ack.
  always_comb begin
    bus.rd_ack  = '0;
    bus.wr_ack  = 1'b0;
    rd_data_d   = rd_data_q;
    if (pop) begin
      if (head == WR_ID) begin
        bus.wr_ack = 1'b1;
      end else begin
        bus.rd_ack[head] = 1'b1;
        rd_data_d[head]  = bus.mem_rdata;
      end
    end
    bus.rd_data = rd_data_d;
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
`ifdef ARB_WR_PRIORITY_EN
    if (accept && grant != WR_ID) rr_ptr_d = wrap_inc(grant, N_RD);
`else
    if (accept) rr_ptr_d = wrap_inc(grant, N_REQ);
`endif
    err_d = err_q || (bus.mem_ack && empty);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rr_ptr_q  <= '0;
      err_q     <= 1'b0;
      rd_data_q <= '0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      err_q     <= err_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign err = err_q;

  ram_arb_id_fifo u_id_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (accept),
    .pop   (pop),
    .din   (grant),
    .head  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Randomized bench: a request/ack-level reference model predicts grants and
// completions; a separate monitor checks routed acks and read data.
module tb_ram_port_arbiter;
  import ram_arb_pkg::*;

  logic clk = 1'b0;
  logic rstn;
  logic err;

  ram_port_arbiter_if bus ();

  ram_port_arbiter dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus),
    .err  (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                   id;
    logic [AXI_WIDTH-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  // Requesters: each holds one pending request until it is accepted.
  bit                        pend   [N_REQ];
  logic [AXI_ADDR_WIDTH-1:0] t_addr [N_REQ];
  logic [AXI_WIDTH-1:0]      t_wdata;
  logic [AXI_STRB_WIDTH-1:0] t_wstrb;

  // Reference model state: round-robin start point and outstanding owners in order.
  int m_rr;
  int m_ids[$];
  bit m_err;

  logic [AXI_WIDTH-1:0] lane [N_RD];

  task automatic check(string name, logic [AXI_WIDTH-1:0] act, logic [AXI_WIDTH-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int model_grant(logic [N_REQ-1:0] en);
`ifdef ARB_WR_PRIORITY_EN
    if (en[N_RD]) return N_RD;
    for (int k = 0; k < N_RD; k++) begin
      if (en[(m_rr + k) % N_RD]) return (m_rr + k) % N_RD;
    end
`else
    for (int k = 0; k < N_REQ; k++) begin
      if (en[(m_rr + k) % N_REQ]) return (m_rr + k) % N_REQ;
    end
`endif
    return -1;
  endfunction

  task automatic do_cycle(int p_req, int p_wait, int p_ack, bit rst_low);
    logic [N_REQ-1:0] en;
    int  g;
    bit  any, can_push, acc;
    @(negedge clk);
    for (int i = 0; i < N_REQ; i++) begin
      if (!pend[i] && $urandom_range(99) < p_req) begin
        pend[i]   = 1'b1;
        t_addr[i] = $urandom;
        if (i == N_RD) begin
          t_wdata = {$urandom, $urandom, $urandom, $urandom};
          t_wstrb = AXI_STRB_WIDTH'($urandom);
        end
      end
    end
    for (int i = 0; i < N_RD; i++) begin
      bus.rd_en[i]   = pend[i];
      bus.rd_addr[i] = t_addr[i];
    end
    bus.wr_en     = pend[N_RD];
    bus.wr_addr   = t_addr[N_RD];
    bus.wr_data   = t_wdata;
    bus.wr_strb   = t_wstrb;
    rstn          = !rst_low;
    bus.mem_wait  = ($urandom_range(99) < p_wait);
    bus.mem_ack   = !rst_low && ($urandom_range(99) < p_ack);
    bus.mem_rdata = {$urandom, $urandom, $urandom, $urandom};
    #1;
    for (int i = 0; i < N_REQ; i++) en[i] = pend[i];
    if (rst_low) begin
      check("mem_en_in_reset", bus.mem_en, 1'b0);
      check("rd_wait_in_reset", bus.rd_wait, {N_RD{1'b1}});
      check("wr_wait_in_reset", bus.wr_wait, 1'b1);
      m_ids.delete();
      m_rr  = 0;
      m_err = 1'b0;
    end else begin
      check("err", err, m_err);
      g        = model_grant(en);
      any      = (en != '0);
      can_push = (m_ids.size() < MAX_OUT) || bus.mem_ack;
      acc      = any && can_push && !bus.mem_wait;
      check("mem_en", bus.mem_en, any && can_push);
      if (any && can_push) begin
        check("mem_we", bus.mem_we, g == N_RD);
        check("mem_addr", bus.mem_addr, t_addr[g]);
        check("mem_wstrb", bus.mem_wstrb, (g == N_RD) ? t_wstrb : '0);
        if (g == N_RD) check("mem_wdata", bus.mem_wdata, t_wdata);
      end
      for (int i = 0; i < N_RD; i++) begin
        if (en[i]) check($sformatf("rd_wait[%0d]", i), bus.rd_wait[i], !(acc && g == i));
      end
      if (en[N_RD]) check("wr_wait", bus.wr_wait, !(acc && g == N_RD));
      if (bus.mem_ack) begin
        if (m_ids.size() > 0) exp_q.push_back('{id: m_ids.pop_front(), data: bus.mem_rdata});
        else m_err = 1'b1;
      end
      if (acc) begin
        m_ids.push_back(g);
        pend[g] = 1'b0;
`ifdef ARB_WR_PRIORITY_EN
        if (g < N_RD) m_rr = (g + 1) % N_RD;
`else
        m_rr = (g + 1) % N_REQ;
`endif
      end
    end
  endtask

  // Monitor: consumes one scoreboard entry per DUT completion.
  initial begin
    logic [N_REQ-1:0] got;
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      got = {bus.wr_ack, bus.rd_ack};
      if (rstn !== 1'b1) begin
        check("ack_in_reset", got, '0);
        for (int i = 0; i < N_RD; i++) lane[i] = '0;
      end else begin
        if (got != '0) begin
          if (exp_q.size() == 0) begin
            check("unexpected_ack", got, '0);
          end else begin
            e = exp_q.pop_front();
            check("ack_route", got, AXI_WIDTH'(1) << e.id);
            if (e.id < N_RD) lane[e.id] = e.data;
          end
        end else if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("missing_ack", got, AXI_WIDTH'(1) << e.id);
        end
        for (int i = 0; i < N_RD; i++) check($sformatf("rd_data[%0d]", i), bus.rd_data[i], lane[i]);
      end
    end
  end

  initial begin
    rstn          = 1'b0;
    bus.rd_en     = '0;
    bus.rd_addr   = '0;
    bus.wr_en     = 1'b0;
    bus.wr_addr   = '0;
    bus.wr_data   = '0;
    bus.wr_strb   = '0;
    bus.mem_rdata = '0;
    bus.mem_wait  = 1'b0;
    bus.mem_ack   = 1'b0;
    t_wdata       = '0;
    t_wstrb       = '0;
    m_rr          = 0;
    m_err         = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      pend[i]   = 1'b0;
      t_addr[i] = '0;
    end
    repeat (2)   do_cycle(100, 0, 0, 1'b1);
    repeat (300) do_cycle(50, 20, 40, 1'b0);
    repeat (100) do_cycle(90, 0, 10, 1'b0);
    repeat (60)  do_cycle(100, 0, 100, 1'b0);
    repeat (60)  do_cycle(60, 60, 50, 1'b0);
    repeat (20)  do_cycle(90, 0, 0, 1'b0);
    do_cycle(0, 0, 0, 1'b1);
    repeat (40)  do_cycle(0, 0, 60, 1'b0);
    repeat (200) do_cycle(70, 30, 35, 1'b0);
    repeat (30)  do_cycle(0, 0, 100, 1'b0);
    @(negedge clk);
    #3;
    check("scoreboard_drained", AXI_WIDTH'(exp_q.size()), '0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
